// File: rtl/mips_ex_muldiv_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_ex_muldiv_ctrl_pkg
// Brief    : Shared widths, MULT/DIV op codes and sequencer state encodings.
// Revision : 1.0  initial release
// ============================================================================
`ifndef MIPS_DATA_WIDTH
`define MIPS_DATA_WIDTH 32
`endif

package mips_ex_muldiv_ctrl_pkg;

    localparam int c_DW = `MIPS_DATA_WIDTH;
    localparam int c_CW = $clog2(c_DW);

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } muldiv_op_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PREP_A = 3'd1,
        ST_PREP_B = 3'd2,
        ST_ITER   = 3'd3,
        ST_FIX_A  = 3'd4,
        ST_FIX_B  = 3'd5,
        ST_DONE   = 3'd6
    } muldiv_state_e;

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

`default_nettype wire

// File: rtl/mips_ex_muldiv_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : mips_ex_muldiv_ctrl_if
// Brief    : Request, HI/LO and shared-ALU borrow signals of the muldiv block.
//            div0 exists only when MIPS_MULDIV_DIV0_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
interface mips_ex_muldiv_ctrl_if
    import mips_ex_muldiv_ctrl_pkg::*;
#(
    parameter int DW = c_DW
);
    logic          req_valid;
    logic          req_ready;
    logic [1:0]    req_op;
    logic [DW-1:0] req_rs;
    logic [DW-1:0] req_rt;
    logic          flush;
    logic          hi_wen;
    logic          lo_wen;
    logic [DW-1:0] wdata;
    logic [DW-1:0] hi;
    logic [DW-1:0] lo;
    logic          busy;
    logic          done;
`ifdef MIPS_MULDIV_DIV0_EN
    logic          div0;
`endif
    logic          muldiv_alu_own;
    logic [DW-1:0] muldiv_req_alu_op1;
    logic [DW-1:0] muldiv_req_alu_op2;
    logic          muldiv_req_alu_add;
    logic          muldiv_req_alu_sub;
    logic [DW-1:0] muldiv_alu_res;
    logic          muldiv_alu_cout;

    modport slave (
        input  req_valid, req_op, req_rs, req_rt, flush, hi_wen, lo_wen, wdata,
               muldiv_alu_res, muldiv_alu_cout,
`ifdef MIPS_MULDIV_DIV0_EN
        output div0,
`endif
        output req_ready, hi, lo, busy, done, muldiv_alu_own,
               muldiv_req_alu_op1, muldiv_req_alu_op2,
               muldiv_req_alu_add, muldiv_req_alu_sub
    );

    modport master (
        output req_valid, req_op, req_rs, req_rt, flush, hi_wen, lo_wen, wdata,
               muldiv_alu_res, muldiv_alu_cout,
`ifdef MIPS_MULDIV_DIV0_EN
        input  div0,
`endif
        input  req_ready, hi, lo, busy, done, muldiv_alu_own,
               muldiv_req_alu_op1, muldiv_req_alu_op2,
               muldiv_req_alu_add, muldiv_req_alu_sub
    );

endinterface

`default_nettype wire

// File: rtl/mips_ex_muldiv_dp.sv
`default_nettype none
// ============================================================================
// Module   : mips_ex_muldiv_dp
// Brief    : Operand, accumulator/remainder and lo/quotient registers with the
//            shift-add / restoring-divide step and ALU operand selection.
// Revision : 1.0  initial release
// ============================================================================
module mips_ex_muldiv_dp
    import mips_ex_muldiv_ctrl_pkg::*;
#(
    parameter int DW = c_DW
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    input  wire logic [2:0]    i_state,
    input  wire logic          i_accept,
    input  wire logic [1:0]    i_op,
    input  wire logic [DW-1:0] i_rs,
    input  wire logic [DW-1:0] i_rt,
    input  wire logic [DW-1:0] i_alu_res,
    input  wire logic          i_alu_cout,
    output logic               o_is_div,
`ifdef MIPS_MULDIV_DIV0_EN
    output logic               o_rt_zero,
`endif
    output logic [DW-1:0]      o_op1,
    output logic [DW-1:0]      o_op2,
    output logic [DW-1:0]      o_hi_val,
    output logic [DW-1:0]      o_lo_val
);

    logic [1:0]    r_op;
    logic [DW-1:0] r_rs;
    logic [DW-1:0] r_rt;
    logic [DW-1:0] r_opa;
    logic [DW-1:0] r_opb;
    logic [DW-1:0] r_acc;
    logic [DW-1:0] r_lo;

    logic          w_is_div;
    logic          w_neg_a;
    logic          w_neg_b;
    logic          w_sdiff;
    logic          w_fixb_en;
    logic          w_take;
    logic [DW-1:0] w_rem_sh;

    assign w_is_div  = op_is_div(r_op);
    assign w_neg_a   = op_is_signed(r_op) & r_rs[DW-1];
    assign w_neg_b   = op_is_signed(r_op) & r_rt[DW-1];
    assign w_sdiff   = w_neg_a ^ w_neg_b;
    assign w_fixb_en = w_is_div ? w_neg_a : w_sdiff;
    assign w_rem_sh  = {r_acc[DW-2:0], r_lo[DW-1]};
    // The bit shifted out of the remainder makes it exceed any divisor.
    assign w_take    = r_acc[DW-1] | i_alu_cout;

    assign o_is_div  = w_is_div;
`ifdef MIPS_MULDIV_DIV0_EN
    assign o_rt_zero = (r_rt == '0);
`endif

    always_comb begin
        o_op1 = '0;
        o_op2 = '0;
        case (i_state)
            ST_PREP_A: o_op2 = r_rs;
            ST_PREP_B: o_op2 = r_rt;
            ST_ITER: begin
                if (w_is_div) begin
                    o_op1 = w_rem_sh;
                    o_op2 = r_opb;
                end else begin
                    o_op1 = r_acc;
                    o_op2 = r_lo[0] ? r_opa : '0;
                end
            end
            ST_FIX_A:  o_op2 = r_lo;
            ST_FIX_B: begin
                // lo already negated in FIX_A; it is zero exactly when it was zero before.
                if (w_is_div) begin
                    o_op2 = r_acc;
                end else begin
                    o_op1 = ~r_acc;
                    o_op2 = {{(DW-1){1'b0}}, (r_lo == '0)};
                end
            end
            default: ;
        endcase
    end

    assign o_hi_val = (i_state == ST_PREP_A) ? r_rs : (w_fixb_en ? i_alu_res : r_acc);
    assign o_lo_val = (i_state == ST_PREP_A) ? '1   : r_lo;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_op  <= '0;
            r_rs  <= '0;
            r_rt  <= '0;
            r_opa <= '0;
            r_opb <= '0;
            r_acc <= '0;
            r_lo  <= '0;
        end else begin
            if (i_accept) begin
                r_op <= i_op;
                r_rs <= i_rs;
                r_rt <= i_rt;
            end
            case (i_state)
                ST_PREP_A: r_opa <= w_neg_a ? i_alu_res : r_rs;
                ST_PREP_B: begin
                    r_opb <= w_neg_b ? i_alu_res : r_rt;
                    r_acc <= '0;
                    r_lo  <= w_is_div ? r_opa : (w_neg_b ? i_alu_res : r_rt);
                end
                ST_ITER: begin
                    if (w_is_div) begin
                        r_acc <= w_take ? i_alu_res : w_rem_sh;
                        r_lo  <= {r_lo[DW-2:0], w_take};
                    end else begin
                        r_acc <= {i_alu_cout, i_alu_res[DW-1:1]};
                        r_lo  <= {i_alu_res[0], r_lo[DW-1:1]};
                    end
                end
                ST_FIX_A: begin
                    if (w_sdiff) begin
                        r_lo <= i_alu_res;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/mips_ex_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mips_ex_muldiv_ctrl
// Brief    : Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO; borrows the
//            shared EX ALU. Optional MIPS_MULDIV_DIV0_EN: early divide-by-zero.
// Revision : 1.0  initial release
// ============================================================================
module mips_ex_muldiv_ctrl
    import mips_ex_muldiv_ctrl_pkg::*;
#(
    parameter int DW = c_DW,
    parameter int CW = c_CW
) (
    input wire logic             clk,
    input wire logic             rst_n,
    mips_ex_muldiv_ctrl_if.slave bus
);

    muldiv_state_e r_state;
    muldiv_state_e w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [DW-1:0] r_hi;
    logic [DW-1:0] r_lo;

    logic          w_accept;
    logic          w_is_div;
    logic          w_own;
    logic          w_add;
    logic          w_sub;
    logic          w_commit;
    logic [DW-1:0] w_op1;
    logic [DW-1:0] w_op2;
    logic [DW-1:0] w_hi_val;
    logic [DW-1:0] w_lo_val;
`ifdef MIPS_MULDIV_DIV0_EN
    logic          w_rt_zero;
`endif

    assign w_accept = (r_state == ST_IDLE) & bus.req_valid & ~bus.flush;

    mips_ex_muldiv_dp #(
        .DW (DW)
    ) u_dp (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_state    (r_state),
        .i_accept   (w_accept),
        .i_op       (bus.req_op),
        .i_rs       (bus.req_rs),
        .i_rt       (bus.req_rt),
        .i_alu_res  (bus.muldiv_alu_res),
        .i_alu_cout (bus.muldiv_alu_cout),
        .o_is_div   (w_is_div),
`ifdef MIPS_MULDIV_DIV0_EN
        .o_rt_zero  (w_rt_zero),
`endif
        .o_op1      (w_op1),
        .o_op2      (w_op2),
        .o_hi_val   (w_hi_val),
        .o_lo_val   (w_lo_val)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (r_state == ST_ITER) begin
            r_cnt <= r_cnt + CW'(1);
        end else begin
            r_cnt <= '0;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_add       = 1'b0;
        w_sub       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_PREP_A;
                end
            end
            ST_PREP_A: begin
                w_sub = 1'b1;
`ifdef MIPS_MULDIV_DIV0_EN
                w_state_nxt = (w_is_div & w_rt_zero) ? ST_DONE : ST_PREP_B;
`else
                w_state_nxt = ST_PREP_B;
`endif
            end
            ST_PREP_B: begin
                w_sub       = 1'b1;
                w_state_nxt = ST_ITER;
            end
            ST_ITER: begin
                w_add = ~w_is_div;
                w_sub = w_is_div;
                if (r_cnt == CW'(DW - 1)) begin
                    w_state_nxt = ST_FIX_A;
                end
            end
            ST_FIX_A: begin
                w_sub       = 1'b1;
                w_state_nxt = ST_FIX_B;
            end
            ST_FIX_B: begin
                w_add       = ~w_is_div;
                w_sub       = w_is_div;
                w_state_nxt = ST_DONE;
            end
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
        if (bus.flush && (r_state != ST_IDLE)) begin
            w_state_nxt = ST_IDLE;
        end
    end

    // Results land in HI/LO on the edge that enters DONE.
    assign w_commit = (w_state_nxt == ST_DONE) & (r_state != ST_DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_commit) begin
            r_hi <= w_hi_val;
            r_lo <= w_lo_val;
        end else if (r_state == ST_IDLE) begin
            if (bus.hi_wen) begin
                r_hi <= bus.wdata;
            end
            if (bus.lo_wen) begin
                r_lo <= bus.wdata;
            end
        end
    end

    assign w_own                  = (r_state != ST_IDLE) & (r_state != ST_DONE);
    assign bus.muldiv_alu_own     = w_own;
    assign bus.muldiv_req_alu_op1 = w_own ? w_op1 : '0;
    assign bus.muldiv_req_alu_op2 = w_own ? w_op2 : '0;
    assign bus.muldiv_req_alu_add = w_own & w_add;
    assign bus.muldiv_req_alu_sub = w_own & w_sub;

    assign bus.req_ready = (r_state == ST_IDLE);
    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.done      = (r_state == ST_DONE);
    assign bus.hi        = r_hi;
    assign bus.lo        = r_lo;
`ifdef MIPS_MULDIV_DIV0_EN
    assign bus.div0      = (r_state == ST_DONE) & w_is_div & w_rt_zero;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mips_ex_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_ex_muldiv_ctrl
// Brief    : Vector table, random ops against an arithmetic model, and
//            flush / reset / MTHI-MTLO corner sequences for the muldiv block.
// Revision : 1.0  initial release
// ============================================================================
module tb_mips_ex_muldiv_ctrl;

    localparam int DW  = 32;
    localparam int LAT = 37;
`ifdef MIPS_MULDIV_DIV0_EN
    localparam int LAT_DIV0 = 2;
`else
    localparam int LAT_DIV0 = 37;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    mips_ex_muldiv_ctrl_if #(.DW(DW)) bus ();

    mips_ex_muldiv_ctrl #(
        .DW (DW),
        .CW (5)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Shared EX adder: cout on subtract means no borrow.
    logic [DW:0] alu_sum;
    always_comb begin
        alu_sum = '0;
        if (bus.muldiv_req_alu_add) begin
            alu_sum = {1'b0, bus.muldiv_req_alu_op1} + {1'b0, bus.muldiv_req_alu_op2};
        end else if (bus.muldiv_req_alu_sub) begin
            alu_sum = {1'b0, bus.muldiv_req_alu_op1} + {1'b0, ~bus.muldiv_req_alu_op2} + (DW+1)'(1);
        end
        bus.muldiv_alu_res  = alu_sum[DW-1:0];
        bus.muldiv_alu_cout = alu_sum[DW];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Architectural result {hi, lo} from plain arithmetic.
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'b00: return sa * sb;
            2'b01: return {32'b0, a} * {32'b0, b};
            default: begin
                if (b == 32'd0) begin
`ifdef MIPS_MULDIV_DIV0_EN
                    return {a, 32'hFFFFFFFF};
`else
                    // quotient magnitude all ones, remainder magnitude |a|, then sign fixes
                    if (op == 2'b11 || !a[31]) return {a, 32'hFFFFFFFF};
                    return {a, 32'h00000001};
`endif
                end
                if (op == 2'b11) return {a % b, a / b};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
        endcase
    endfunction

    task automatic run_chk(input string tag, input logic [1:0] op, input logic [31:0] rs, rt,
                           input logic [31:0] ehi, elo, input int elat);
        int   lat;
        logic busy_ok;
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_rs    = rs;
        bus.req_rt    = rt;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        lat     = 1;
        busy_ok = 1'b1;
        while (!bus.done && lat < 100) begin
            busy_ok = busy_ok & bus.busy & ~bus.req_ready;
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, " latency"}, 64'(lat), 64'(elat));
        chk({tag, " busy"}, {63'b0, busy_ok & bus.busy}, 64'd1);
        chk({tag, " hi:lo"}, {bus.hi, bus.lo}, {ehi, elo});
        chk({tag, " own_in_done"}, {63'b0, bus.muldiv_alu_own}, 64'd0);
`ifdef MIPS_MULDIV_DIV0_EN
        chk({tag, " div0"}, {63'b0, bus.div0}, {63'b0, (op[1] && rt == 32'd0)});
`endif
        @(posedge clk); #1;
        chk({tag, " ready_after"}, {63'b0, bus.req_ready}, 64'd1);
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } vec_t;

    vec_t vecs[11];

    initial begin
        int          lat;
        logic        saw_done;
        logic [1:0]  rop;
        logic [31:0] rrs, rrt;
        logic [63:0] exp;

        vecs[0]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, LAT};
        vecs[1]  = '{2'b00, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, LAT};
        vecs[2]  = '{2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       LAT};
        vecs[3]  = '{2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, LAT};
        vecs[4]  = '{2'b11, 32'h0000ABCD, 32'd0,        32'h0000ABCD, 32'hFFFFFFFF, LAT_DIV0};
        vecs[5]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, LAT};
        vecs[6]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, LAT};
        vecs[7]  = '{2'b00, 32'hFFFFFFFF, 32'd0,        32'h00000000, 32'h00000000, LAT};
        vecs[8]  = '{2'b10, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, LAT};
        vecs[9]  = '{2'b11, 32'd5,        32'hFFFFFFFF, 32'd5,        32'd0,        LAT};
        vecs[10] = '{2'b11, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'd1,        LAT};

        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_op    = 2'b00;
        bus.req_rs    = '0;
        bus.req_rt    = '0;
        bus.flush     = 1'b0;
        bus.hi_wen    = 1'b0;
        bus.lo_wen    = 1'b0;
        bus.wdata     = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        chk("reset ready/busy/done", {61'b0, bus.req_ready, bus.busy, bus.done}, 64'h4);
        chk("reset hi:lo", {bus.hi, bus.lo}, 64'd0);
        chk("reset alu ctl", {61'b0, bus.muldiv_alu_own, bus.muldiv_req_alu_add, bus.muldiv_req_alu_sub}, 64'd0);
        chk("reset alu ops", {bus.muldiv_req_alu_op1, bus.muldiv_req_alu_op2}, 64'd0);

        for (int i = 0; i < 11; i++) begin
            run_chk($sformatf("vec%0d", i), vecs[i].op, vecs[i].rs, vecs[i].rt,
                    vecs[i].hi, vecs[i].lo, vecs[i].lat);
        end

        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            rrs = $urandom;
            rrt = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom);
            if ($urandom_range(0, 3) == 0) rrt = rrt & 32'h000000FF;
            exp = model(rop, rrs, rrt);
            run_chk($sformatf("rand%0d op%0d", i, rop), rop, rrs, rrt, exp[63:32], exp[31:0],
                    (rop[1] && rrt == 32'd0) ? LAT_DIV0 : LAT);
        end

        // MTHI/MTLO then flush mid-multiply: HI/LO survive, no done.
        bus.hi_wen = 1'b1; bus.lo_wen = 1'b1; bus.wdata = 32'h12345678;
        @(posedge clk); #1;
        bus.hi_wen = 1'b0; bus.lo_wen = 1'b0;
        chk("mthi/mtlo", {bus.hi, bus.lo}, {2{32'h12345678}});
        bus.req_valid = 1'b1; bus.req_op = 2'b01; bus.req_rs = 32'hFFFFFFFF; bus.req_rt = 32'h3;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        lat = 1; saw_done = bus.done;
        while (lat < 10) begin
            @(posedge clk); #1;
            lat++;
            saw_done = saw_done | bus.done;
        end
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        chk("flush ready", {63'b0, bus.req_ready}, 64'd1);
        chk("flush busy", {63'b0, bus.busy}, 64'd0);
        repeat (40) begin
            saw_done = saw_done | bus.done;
            @(posedge clk); #1;
        end
        chk("flush no done", {63'b0, saw_done}, 64'd0);
        chk("flush hi:lo", {bus.hi, bus.lo}, {2{32'h12345678}});

        // MTLO in the accepting cycle is applied, then overwritten at DONE.
        bus.lo_wen = 1'b1; bus.wdata = 32'hDEADBEEF;
        bus.req_valid = 1'b1; bus.req_op = 2'b01; bus.req_rs = 32'd6; bus.req_rt = 32'd7;
        @(posedge clk); #1;
        bus.lo_wen = 1'b0; bus.req_valid = 1'b0;
        chk("accept+mtlo lo", {32'b0, bus.lo}, 64'hDEADBEEF);
        lat = 1;
        while (!bus.done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("accept+mtlo latency", 64'(lat), 64'(LAT));
        // flush during DONE: result already committed
        bus.flush = 1'b1;
        chk("accept+mtlo result", {bus.hi, bus.lo}, 64'd42);
        @(posedge clk); #1;
        bus.flush = 1'b0;
        chk("flush in done hi:lo", {bus.hi, bus.lo}, 64'd42);
        chk("flush in done ready", {63'b0, bus.req_ready}, 64'd1);

        // MTHI ignored while busy, then reset in ITER.
        bus.hi_wen = 1'b1; bus.wdata = 32'h11111111;
        @(posedge clk); #1;
        bus.hi_wen = 1'b0;
        bus.req_valid = 1'b1; bus.req_op = 2'b01; bus.req_rs = 32'h1234; bus.req_rt = 32'h5678;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        lat = 1;
        while (lat < 20) begin
            bus.hi_wen = (lat == 5);
            bus.wdata  = 32'hA5A5A5A5;
            @(posedge clk); #1;
            lat++;
            if (lat == 6) chk("mthi while busy", {32'b0, bus.hi}, 64'h11111111);
        end
        bus.hi_wen = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midrst ready/busy/done", {61'b0, bus.req_ready, bus.busy, bus.done}, 64'h4);
        chk("midrst hi:lo", {bus.hi, bus.lo}, 64'd0);
        chk("midrst alu ctl", {61'b0, bus.muldiv_alu_own, bus.muldiv_req_alu_add, bus.muldiv_req_alu_sub}, 64'd0);
        chk("midrst alu ops", {bus.muldiv_req_alu_op1, bus.muldiv_req_alu_op2}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_chk("post reset multu", 2'b01, 32'd9, 32'd9, 32'd0, 32'd81, LAT);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mips_ex_muldiv_ctrl.md
Name: mips_ex_muldiv_ctrl

Overview:
- Iterative MULT/MULTU/DIV/DIVU sequencer in the EX stage.
- Borrows the shared EX ALU adder through its op1/op2/add/sub request interface for one add or subtract per cycle.
- Owns the architectural HI/LO registers.
- Asserts busy so the pipeline stalls while an operation runs.

Parameters:
DW, 32 (`MIPS_DATA_WIDTH), operand and HI/LO width
CW, 5, iteration counter width (log2 DW)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
req_valid  in  1  operation request from ID/EX
req_ready  out  1  block idle and able to accept
req_op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
req_rs  in  DW  multiplicand / dividend
req_rt  in  DW  multiplier / divisor
flush  in  1  abort current operation
hi_wen  in  1  MTHI write
lo_wen  in  1  MTLO write
wdata  in  DW  MTHI/MTLO data
hi  out  DW  architectural HI
lo  out  DW  architectural LO
busy  out  1  stall request to pipeline
done  out  1  one-cycle completion pulse
muldiv_alu_own  out  1  block drives the shared ALU this cycle
muldiv_req_alu_op1  out  DW  ALU operand 1
muldiv_req_alu_op2  out  DW  ALU operand 2
muldiv_req_alu_add  out  1  request add
muldiv_req_alu_sub  out  1  request subtract
muldiv_alu_res  in  DW  ALU result (combinational, same cycle)
muldiv_alu_cout  in  1  ALU carry-out; 1 means no borrow on subtract

Behaviour:
- Reset (rst_n=0 at clk edge) from any state:
  - state IDLE; hi=lo=0.
  - busy=done=0; req_ready=1 after reset.
  - All ALU request outputs 0.
- States and transitions:
  - IDLE -> PREP_A -> PREP_B -> ITER (exactly DW cycles, counter 0..DW-1) -> FIX_A -> FIX_B -> DONE -> IDLE.
- Handshake:
  - Accept on edge where state==IDLE & req_valid & ~flush; latch op, rs, rt.
  - req_ready = (state==IDLE); busy = (state!=IDLE).
  - muldiv_alu_own = busy & (state!=DONE). ALU request outputs are 0 whenever own=0.
- PREP_A / PREP_B:
  - Signed ops with a negative operand: ALU sub 0-rs, then 0-rt, producing magnitudes. 0x80000000 maps to 2^31 unsigned.
  - Unsigned ops and non-negative operands: the ALU still runs, result ignored, so latency is fixed.
- ITER, multiply:
  - op1=acc_hi, op2 = lo[0] ? mcand : 0, add.
  - {cout, res, lo} shifted right 1 into {acc_hi, lo}.
- ITER, divide (restoring):
  - Shift {rem, quo} left 1.
  - Sub rem_shifted - divisor.
  - If the bit shifted out of rem is 1, or cout=1: rem = res and quo[0] = 1; else rem is kept and quo[0] = 0.
- FIX_A / FIX_B:
  - MULT with operand signs differing: 64-bit negate. FIX_A lo = 0-lo; FIX_B hi = ~hi + (lo_pre==0) via add.
  - DIV: FIX_A quotient = 0-quo if signs differ; FIX_B remainder = 0-rem if dividend negative.
  - Otherwise pass-through.
- DONE:
  - hi/lo architectural registers update on the edge entering DONE.
  - done=1 for exactly that one cycle.
  - done asserts 37 cycles after the accepting edge (DW=32).
- Divide by zero (no macro): algorithm outcome stands. DIVU gives lo=all ones, hi=dividend.
- flush:
  - In any busy state: -> IDLE next edge, no done, hi/lo unchanged.
  - flush in DONE cycle: hi/lo already committed, done still seen this cycle.
- MTHI/MTLO:
  - hi_wen/lo_wen take effect only in IDLE.
  - While busy they are ignored.
  - Same-cycle req accept and write: the write is applied, then the op later overwrites hi/lo at DONE.
- Reset mid-operation: immediate return to IDLE with hi=lo=0.

Optional Feature:
MIPS_MULDIV_DIV0_EN
- Defined:
  - In PREP_A, DIV/DIVU with rt==0 jumps directly to DONE.
  - Result: hi=rs, lo=all ones (signed included).
  - done asserts 2 cycles after acceptance.
  - Extra output div0 (1 bit) pulses with done.
- Undefined: no early exit, no div0 port, fixed 37-cycle latency.

Decomposition:
- Shared package/defines (mips_defines):
  - MULDIV op encodings.
  - FSM state encodings.
  - DW/CW constants derived from `MIPS_DATA_WIDTH.
- Sub-module mips_ex_muldiv_dp holds:
  - acc/rem, lo/quo, operand and sign-flag registers;
  - shift logic.
- The controller FSM and counter stay in the top module.

Test Plan:
1. MULTU rs=0xFFFFFFFF rt=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; done 37 cycles after accept; busy high throughout.
2. MULT rs=0xFFFFFFFD (-3) rt=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
3. DIVU 100/7 -> lo=14, hi=2. DIV 0xFFFFFFF9 (-7)/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
4. MULTU started with hi=lo=0x12345678 (via MTHI/MTLO), flush asserted 10 cycles after accept -> no done, hi/lo remain 0x12345678, req_ready=1 next cycle.
5. DIVU 0x0000ABCD/0 -> without macro: lo=0xFFFFFFFF, hi=0x0000ABCD at cycle 37; with MIPS_MULDIV_DIV0_EN: same values, done and div0 at cycle 2.
6. rst_n low during ITER (cycle 20) -> next edge state IDLE, hi=lo=0, busy=0, all ALU requests 0; hi_wen with wdata=0xA5A5A5A5 while busy -> hi unchanged.
